// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the CPU/DMA memory arbiter.
package mem_arb_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } arb_port_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the CPU and DMA requesters.
// ARB_ROUND_ROBIN_EN selects alternating tie-break; otherwise the CPU always wins ties.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  arb_port_t  last,
    output logic       gnt_valid,
    output arb_port_t  gnt_port
);

    always_comb begin
        gnt_valid = req[0] | req[1];
        gnt_port  = PORT_CPU;
        if (req[0] && req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
            // Favour whichever port did not win the previous grant.
            gnt_port = (last == PORT_CPU) ? PORT_DMA : PORT_CPU;
`else
            gnt_port = PORT_CPU;
`endif
        end else if (req[1]) begin
            gnt_port = PORT_DMA;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    // last only matters for round-robin tie-breaking.
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU, DMA) arbiter for a single-ported memory: latch, one-cycle access, registered ack.
// Tie-break policy is set by ARB_ROUND_ROBIN_EN in arb_pick.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] WriteData,
    input  logic [DW-1:0] ReadData,
    output logic          busy
);

    arb_state_t    state_q, state_d;
    arb_port_t     owner_q, owner_d;
    arb_port_t     last_q, last_d;
    logic          op_we_q, op_we_d;
    logic [AW-1:0] op_addr_q, op_addr_d;
    logic [DW-1:0] op_wdata_q, op_wdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;

    logic          gnt_valid;
    arb_port_t     gnt_port;

    arb_pick u_pick (
        .req       ({dma_req, cpu_req}),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        op_we_d     = op_we_q;
        op_addr_d   = op_addr_q;
        op_wdata_d  = op_wdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_port;
                    last_d  = gnt_port;
                    state_d = SERVE;
                    if (gnt_port == PORT_DMA) begin
                        op_we_d    = dma_we;
                        op_addr_d  = dma_addr;
                        op_wdata_d = dma_wdata;
                    end else begin
                        op_we_d    = cpu_we;
                        op_addr_d  = cpu_addr;
                        op_wdata_d = cpu_wdata;
                    end
                end
            end
            SERVE: begin
                // The latched access completes regardless of the requester's current req.
                state_d = IDLE;
                if (owner_q == PORT_CPU) begin
                    cpu_ack_d = 1'b1;
                    if (!op_we_q) cpu_rdata_d = ReadData;
                end else begin
                    dma_ack_d = 1'b1;
                    if (!op_we_q) dma_rdata_d = ReadData;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= PORT_CPU;
            last_q      <= PORT_DMA;
            op_we_q     <= 1'b0;
            op_addr_q   <= '0;
            op_wdata_q  <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            op_we_q     <= op_we_d;
            op_addr_q   <= op_addr_d;
            op_wdata_q  <= op_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Strobes are gated by rst so a reset landing in SERVE never writes memory.
    assign busy      = (state_q == SERVE);
    assign MemRead   = busy & ~op_we_q & ~rst;
    assign MemWrite  = busy &  op_we_q & ~rst;
    assign Address   = busy ? op_addr_q  : '0;
    assign WriteData = busy ? op_wdata_q : '0;

    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed test of mem_arbiter with a word-addressed memory model and an ack scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_ack, dma_ack;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        MemRead, MemWrite, busy;
    logic [31:0] Address, WriteData, ReadData;

    logic [31:0] mem [0:255];

    typedef struct {
        logic        is_dma;
        logic        is_read;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .busy(busy)
    );

    assign ReadData = MemRead ? mem[Address[9:2]] : 32'h0;
    always @(posedge clk) if (MemWrite) mem[Address[9:2]] <= WriteData;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_dma, input logic is_read, input logic [31:0] rdata);
        exp_t e;
        e.is_dma = is_dma; e.is_read = is_read; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every ack pops one expected transaction.
    always @(negedge clk) begin
        if (cpu_ack && dma_ack) begin
            checks++; errors++;
            $display("FAIL both_acks: cpu_ack=1 dma_ack=1 required at most one");
        end else if (cpu_ack || dma_ack) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got %s ack, required none", cpu_ack ? "cpu" : "dma");
            end else begin
                e = exp_q.pop_front();
                if (e.is_dma != dma_ack) begin
                    errors++;
                    $display("FAIL ack_port: got %s, required %s", dma_ack ? "dma" : "cpu", e.is_dma ? "dma" : "cpu");
                end else if (e.is_read && ((dma_ack ? dma_rdata : cpu_rdata) !== e.rdata)) begin
                    errors++;
                    $display("FAIL ack_rdata: got %h required %h", dma_ack ? dma_rdata : cpu_rdata, e.rdata);
                end else begin
                    $display("ack %s %s rdata=%h ok", dma_ack ? "dma" : "cpu", e.is_read ? "rd" : "wr",
                             dma_ack ? dma_rdata : cpu_rdata);
                end
            end
        end
    end

    initial begin
        int n_ack, n_cpu;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'hDEADBEEF;   // 0x10
        mem[8'h20] = 32'hAAAA0000;   // 0x80
        mem[8'h40] = 32'h11110000;   // 0x100
        mem[8'h41] = 32'h22220000;   // 0x104
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        tick(); tick();

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        check("rst_dma_ack", {31'd0, dma_ack}, 32'd0);
        check("rst_memread", {31'd0, MemRead}, 32'd0);
        check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        check("rst_address", Address, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Single CPU read
        push(1'b0, 1'b1, 32'hDEADBEEF);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        tick();
        check("rd_memread_c1", {31'd0, MemRead}, 32'd1);
        check("rd_addr_c1", Address, 32'h10);
        check("rd_busy_c1", {31'd0, busy}, 32'd1);
        cpu_req = 0;
        tick();
        check("rd_ack_c2", {31'd0, cpu_ack}, 32'd1);
        check("rd_rdata_c2", cpu_rdata, 32'hDEADBEEF);
        tick();
        check("rd_rdata_held", cpu_rdata, 32'hDEADBEEF);

        // DMA write then CPU read-back
        push(1'b1, 1'b0, 32'h0);
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h12345678;
        tick();
        check("dw_memwrite_c1", {31'd0, MemWrite}, 32'd1);
        check("dw_wdata_c1", WriteData, 32'h12345678);
        dma_req = 0;
        tick();
        check("dw_ack_c2", {31'd0, dma_ack}, 32'd1);
        push(1'b0, 1'b1, 32'h12345678);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        tick();
        cpu_req = 0;
        tick();
        check("rb_rdata", cpu_rdata, 32'h12345678);
        tick();

        // CPU write with req dropped during SERVE
        push(1'b0, 1'b0, 32'h0);
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hCAFEF00D;
        tick();
        cpu_req = 0;
        tick();
        check("drop_ack", {31'd0, cpu_ack}, 32'd1);
        check("drop_mem", mem[8'h08], 32'hCAFEF00D);
        tick();

        // Reset during SERVE of a DMA write
        dma_req = 1; dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'h55555555;
        tick();
        rst = 1; dma_req = 0;
        #1;
        check("rstsv_memwrite", {31'd0, MemWrite}, 32'd0);
        tick();
        check("rstsv_mem", mem[8'h20], 32'hAAAA0000);
        check("rstsv_dma_ack", {31'd0, dma_ack}, 32'd0);
        check("rstsv_busy", {31'd0, busy}, 32'd0);
        check("rstsv_addr", Address, 32'd0);
        check("rstsv_cpu_rdata", cpu_rdata, 32'd0);
        rst = 0;
        tick();
        check("rstsv_dma_ack_after", {31'd0, dma_ack}, 32'd0);

        // Idle bus
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_strobes", {29'd0, MemRead, MemWrite, busy}, 32'd0);
        end

        // Continuous contention for 8 accesses, starting from reset
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 8; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (i % 2 == 0) push(1'b0, 1'b1, 32'h11110000);
            else            push(1'b1, 1'b1, 32'h22220000);
`else
            push(1'b0, 1'b1, 32'h11110000);
`endif
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        dma_req = 1; dma_we = 0; dma_addr = 32'h104;
        n_ack = 0; n_cpu = 0;
        for (int c = 0; c < 60 && n_ack < 8; c++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) begin
                n_ack++;
                if (cpu_ack) n_cpu++;
            end
            if (n_ack == 8) begin
                cpu_req = 0; dma_req = 0;
            end
        end
        cpu_req = 0; dma_req = 0;
        check("cont_total_acks", n_ack, 32'd8);
`ifdef ARB_ROUND_ROBIN_EN
        check("cont_cpu_acks", n_cpu, 32'd4);
`else
        check("cont_cpu_acks", n_cpu, 32'd8);
`endif
        tick(); tick(); tick(); tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
